e203_subsys_pllcfg_seq: RTL and testbench



---
 rtl/e203_subsys_pllcfg_seq.sv | 240 ++++++++++++++++++++++++
 tb/tb_e203_subsys_pllcfg_seq.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/e203_subsys_pllcfg_seq.sv
`timescale 1ns/1ps
// PLL control sequencer for the hfextclk clock generator: orders bypass, reset, sleep and M/N/OD updates with timed waits.
// Registered outputs; a request is taken only in IDLE with no pending sleep, otherwise cfg_ready stays low.
module e203_subsys_pllcfg_seq #(
   parameter int SW_CYC   = 8,
   parameter int RST_CYC  = 16,
   parameter int LOCK_CYC = 1024,
   parameter int CNT_W    = 11
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cfg_valid,
   output logic       cfg_ready,
   input  logic       cfg_use_pll,
   input  logic [1:0] cfg_od,
   input  logic [7:0] cfg_m,
   input  logic [4:0] cfg_n,
   input  logic       cfg_divby1,
   input  logic [5:0] cfg_div,
   input  logic       sleep_req,
   output logic       pllbypass,
   output logic       pll_RESET,
   output logic       pll_ASLEEP,
   output logic [1:0] pll_OD,
   output logic [7:0] pll_M,
   output logic [4:0] pll_N,
   output logic       plloutdivby1,
   output logic [5:0] plloutdiv,
   output logic       busy,
   output logic       done,
   output logic       cfg_err
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_BYP, ST_RST, ST_LOCK, ST_SWITCH, ST_DONE, ST_SLEEP
   } state_t;

   localparam logic [CNT_W-1:0] SW_LD   = CNT_W'(SW_CYC - 1);
   localparam logic [CNT_W-1:0] RST_LD  = CNT_W'(RST_CYC - 1);
   localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_CYC - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             slp_q, slp_d;
   logic             pll_en_q, pll_en_d;
   logic             byp_q, byp_d;
   logic             rst_q, rst_d;
   logic             asl_q, asl_d;
   logic [1:0]       od_q, od_d;
   logic [7:0]       m_q, m_d;
   logic [4:0]       n_q, n_d;
   logic             divby1_q, divby1_d;
   logic [5:0]       div_q, div_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             shd_use_q, shd_use_d;
   logic [1:0]       shd_od_q, shd_od_d;
   logic [7:0]       shd_m_q, shd_m_d;
   logic [4:0]       shd_n_q, shd_n_d;
   logic             shd_divby1_q, shd_divby1_d;
   logic [5:0]       shd_div_q, shd_div_d;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      slp_d        = slp_q;
      pll_en_d     = pll_en_q;
      byp_d        = byp_q;
      rst_d        = rst_q;
      asl_d        = asl_q;
      od_d         = od_q;
      m_d          = m_q;
      n_d          = n_q;
      divby1_d     = divby1_q;
      div_d        = div_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      shd_use_d    = shd_use_q;
      shd_od_d     = shd_od_q;
      shd_m_d      = shd_m_q;
      shd_n_d      = shd_n_q;
      shd_divby1_d = shd_divby1_q;
      shd_div_d    = shd_div_q;
      unique case (state_q)
         ST_IDLE: begin
            // Sleep has priority over a simultaneous configuration request.
            if (sleep_req) begin
               state_d = ST_BYP;
               cnt_d   = SW_LD;
               slp_d   = 1'b1;
               byp_d   = 1'b1;
            end else if (cfg_valid) begin
               if (cfg_use_pll && (cfg_m == 8'd0 || cfg_n == 5'd0)) begin
                  err_d = 1'b1;
               end else begin
                  shd_use_d    = cfg_use_pll;
                  shd_od_d     = cfg_od;
                  shd_m_d      = cfg_m;
                  shd_n_d      = cfg_n;
                  shd_divby1_d = cfg_divby1;
                  shd_div_d    = cfg_div;
                  state_d      = ST_BYP;
                  cnt_d        = SW_LD;
                  slp_d        = 1'b0;
                  byp_d        = 1'b1;
               end
            end
         end
         ST_BYP: begin
            if (cnt_q == '0) begin
               if (slp_q) begin
                  state_d = ST_SLEEP;
                  asl_d   = 1'b1;
                  rst_d   = 1'b1;
                  byp_d   = 1'b1;
               end else begin
                  state_d  = ST_RST;
                  cnt_d    = RST_LD;
                  rst_d    = 1'b1;
                  asl_d    = 1'b0;
                  od_d     = shd_od_q;
                  m_d      = shd_m_q;
                  n_d      = shd_n_q;
                  divby1_d = shd_divby1_q;
                  div_d    = shd_div_q;
                  pll_en_d = shd_use_q;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RST: begin
            if (cnt_q == '0) begin
               if (pll_en_q) begin
                  state_d = ST_LOCK;
                  cnt_d   = LOCK_LD;
                  rst_d   = 1'b0;
               end else begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_LOCK: begin
            if (cnt_q == '0) begin
               state_d = ST_SWITCH;
               cnt_d   = SW_LD;
               byp_d   = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_SWITCH: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_SLEEP: begin
            // Wake re-applies the held M/N/OD; pll_en keeps its pre-sleep value.
            if (!sleep_req) begin
               if (pll_en_q) begin
                  state_d = ST_RST;
                  cnt_d   = RST_LD;
                  asl_d   = 1'b0;
                  rst_d   = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         slp_q        <= 1'b0;
         pll_en_q     <= 1'b0;
         byp_q        <= 1'b1;
         rst_q        <= 1'b1;
         asl_q        <= 1'b0;
         od_q         <= 2'd0;
         m_q          <= 8'd16;
         n_q          <= 5'd1;
         divby1_q     <= 1'b1;
         div_q        <= 6'd0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         shd_use_q    <= 1'b0;
         shd_od_q     <= 2'd0;
         shd_m_q      <= 8'd0;
         shd_n_q      <= 5'd0;
         shd_divby1_q <= 1'b0;
         shd_div_q    <= 6'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         slp_q        <= slp_d;
         pll_en_q     <= pll_en_d;
         byp_q        <= byp_d;
         rst_q        <= rst_d;
         asl_q        <= asl_d;
         od_q         <= od_d;
         m_q          <= m_d;
         n_q          <= n_d;
         divby1_q     <= divby1_d;
         div_q        <= div_d;
         done_q       <= done_d;
         err_q        <= err_d;
         shd_use_q    <= shd_use_d;
         shd_od_q     <= shd_od_d;
         shd_m_q      <= shd_m_d;
         shd_n_q      <= shd_n_d;
         shd_divby1_q <= shd_divby1_d;
         shd_div_q    <= shd_div_d;
      end
   end

   assign cfg_ready    = (state_q == ST_IDLE) && !sleep_req;
   assign busy         = (state_q != ST_IDLE);
   assign pllbypass    = byp_q;
   assign pll_RESET    = rst_q;
   assign pll_ASLEEP   = asl_q;
   assign pll_OD       = od_q;
   assign pll_M        = m_q;
   assign pll_N        = n_q;
   assign plloutdivby1 = divby1_q;
   assign plloutdiv    = div_q;
   assign done         = done_q;
   assign cfg_err      = err_q;

endmodule

// File: tb/tb_e203_subsys_pllcfg_seq.sv
`timescale 1ns/1ps
// Bench for e203_subsys_pllcfg_seq: scenario tasks plus a done-pulse scoreboard.
// A value quoted as due "at T+k" after a handshake edge T is seen here once cyc == T+k-1.
module tb_e203_subsys_pllcfg_seq;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic       cfg_use_pll = 1'b0;
   logic [1:0] cfg_od = '0;
   logic [7:0] cfg_m = '0;
   logic [4:0] cfg_n = '0;
   logic       cfg_divby1 = 1'b0;
   logic [5:0] cfg_div = '0;
   logic       sleep_req = 1'b0;
   logic       pllbypass, pll_RESET, pll_ASLEEP;
   logic [1:0] pll_OD;
   logic [7:0] pll_M;
   logic [4:0] pll_N;
   logic       plloutdivby1;
   logic [5:0] plloutdiv;
   logic       busy, done, cfg_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      int         at;
      logic [7:0] m;
      logic [4:0] n;
      logic [1:0] od;
      logic       byp;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   localparam logic [25:0] RESET_VEC = {1'b1, 1'b1, 1'b0, 2'd0, 8'd16, 5'd1, 1'b1, 6'd0, 1'b1};

   e203_subsys_pllcfg_seq dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_use_pll(cfg_use_pll),
      .cfg_od(cfg_od), .cfg_m(cfg_m), .cfg_n(cfg_n),
      .cfg_divby1(cfg_divby1), .cfg_div(cfg_div), .sleep_req(sleep_req),
      .pllbypass(pllbypass), .pll_RESET(pll_RESET), .pll_ASLEEP(pll_ASLEEP),
      .pll_OD(pll_OD), .pll_M(pll_M), .pll_N(pll_N),
      .plloutdivby1(plloutdivby1), .plloutdiv(plloutdiv),
      .busy(busy), .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard consumer and the bypass safety invariant, both sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (!pllbypass && (pll_RESET || pll_ASLEEP)) begin
            errors++;
            $display("FAIL bypass_invariant cyc=%0d got byp=%b rst=%b asl=%b want rst=0 asl=0 while byp=0",
                     cyc, pllbypass, pll_RESET, pll_ASLEEP);
         end
      end
      if (done === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected cyc=%0d got done=1 want no pulse", cyc);
         end else begin
            e = sb.pop_front();
            if (cyc !== e.at || pll_M !== e.m || pll_N !== e.n || pll_OD !== e.od || pllbypass !== e.byp) begin
               errors++;
               $display("FAIL done_scoreboard got cyc=%0d M=%0d N=%0d OD=%0d byp=%b want cyc=%0d M=%0d N=%0d OD=%0d byp=%b",
                        cyc, pll_M, pll_N, pll_OD, pllbypass, e.at, e.m, e.n, e.od, e.byp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int t);
      while (cyc < t) tick();
   endtask

   task automatic drive_cfg(input logic use_pll, input logic [7:0] m, input logic [4:0] n,
                            input logic [1:0] od, input logic divby1, input logic [5:0] div);
      cfg_use_pll = use_pll;
      cfg_m       = m;
      cfg_n       = n;
      cfg_od      = od;
      cfg_divby1  = divby1;
      cfg_div     = div;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (20) tick();
      checks++;
      if ({pllbypass, pll_RESET, pll_ASLEEP, pll_OD, pll_M, pll_N, plloutdivby1, plloutdiv, cfg_ready} !== RESET_VEC) begin
         errors++;
         $display("FAIL reset_outputs got %h want %h", {pllbypass, pll_RESET, pll_ASLEEP, pll_OD, pll_M, pll_N,
                  plloutdivby1, plloutdiv, cfg_ready}, RESET_VEC);
      end
      checks++;
      if ({busy, done, cfg_err} !== 3'b000) begin
         errors++;
         $display("FAIL reset_status got busy/done/err=%b want 000", {busy, done, cfg_err});
      end
   endtask

   task automatic test_cfg_pll();
      int t;
      drive_cfg(1'b1, 8'd40, 5'd2, 2'd1, 1'b0, 6'd3);
      cfg_valid = 1'b1;
      tick();
      t = cyc;
      cfg_valid = 1'b0;
      sb.push_back('{at: t + 1056, m: 8'd40, n: 5'd2, od: 2'd1, byp: 1'b0});
      checks++;
      if ({busy, cfg_ready, cfg_err} !== 3'b100) begin
         errors++;
         $display("FAIL cfg_accept got busy/ready/err=%b want 100", {busy, cfg_ready, cfg_err});
      end
      run_to(t + 7);
      checks++;
      if (pll_M !== 8'd16) begin
         errors++;
         $display("FAIL cfg_m_early got %0d want 16", pll_M);
      end
      run_to(t + 8);
      checks++;
      if ({pll_M, pll_N, pll_OD, plloutdivby1, plloutdiv, pll_RESET, pllbypass} !== {8'd40, 5'd2, 2'd1, 1'b0, 6'd3, 1'b1, 1'b1}) begin
         errors++;
         $display("FAIL cfg_load got M=%0d N=%0d OD=%0d d1=%b div=%0d rst=%b byp=%b want 40 2 1 0 3 1 1",
                  pll_M, pll_N, pll_OD, plloutdivby1, plloutdiv, pll_RESET, pllbypass);
      end
      run_to(t + 23);
      checks++;
      if (pll_RESET !== 1'b1) begin
         errors++;
         $display("FAIL cfg_rst_hold got %b want 1", pll_RESET);
      end
      run_to(t + 24);
      checks++;
      if ({pll_RESET, pllbypass} !== 2'b01) begin
         errors++;
         $display("FAIL cfg_rst_release got rst/byp=%b want 01", {pll_RESET, pllbypass});
      end
      run_to(t + 1047);
      checks++;
      if (pllbypass !== 1'b1) begin
         errors++;
         $display("FAIL cfg_byp_hold got %b want 1", pllbypass);
      end
      run_to(t + 1048);
      checks++;
      if (pllbypass !== 1'b0) begin
         errors++;
         $display("FAIL cfg_byp_fall got %b want 0", pllbypass);
      end
      run_to(t + 1057);
      checks++;
      if ({cfg_ready, busy, done} !== 3'b100) begin
         errors++;
         $display("FAIL cfg_end got ready/busy/done=%b want 100", {cfg_ready, busy, done});
      end
   endtask

   task automatic test_reject();
      drive_cfg(1'b1, 8'd5, 5'd0, 2'd3, 1'b1, 6'd9);
      cfg_valid = 1'b1;
      tick();
      cfg_valid = 1'b0;
      checks++;
      if (cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL reject_err got %b want 1", cfg_err);
      end
      checks++;
      if ({pll_M, pll_N, pll_OD, pllbypass, pll_RESET, cfg_ready, busy} !== {8'd40, 5'd2, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reject_hold got M=%0d N=%0d OD=%0d byp=%b rst=%b ready=%b busy=%b want 40 2 1 0 0 1 0",
                  pll_M, pll_N, pll_OD, pllbypass, pll_RESET, cfg_ready, busy);
      end
      tick();
      checks++;
      if (cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL reject_pulse got %b want 0", cfg_err);
      end
   endtask

   task automatic test_sleep();
      int s, w;
      sleep_req = 1'b1;
      tick();
      s = cyc;
      checks++;
      if ({pllbypass, busy, cfg_ready} !== 3'b110) begin
         errors++;
         $display("FAIL sleep_byp got byp/busy/ready=%b want 110", {pllbypass, busy, cfg_ready});
      end
      run_to(s + 7);
      checks++;
      if (pll_ASLEEP !== 1'b0) begin
         errors++;
         $display("FAIL sleep_asl_early got %b want 0", pll_ASLEEP);
      end
      run_to(s + 8);
      checks++;
      if ({pll_ASLEEP, pll_RESET, pllbypass} !== 3'b111) begin
         errors++;
         $display("FAIL sleep_enter got asl/rst/byp=%b want 111", {pll_ASLEEP, pll_RESET, pllbypass});
      end
      run_to(s + 49);
      sleep_req = 1'b0;
      w = s + 50;
      sb.push_back('{at: w + 1048, m: 8'd40, n: 5'd2, od: 2'd1, byp: 1'b0});
      run_to(w);
      checks++;
      if ({pll_ASLEEP, pll_RESET, pll_M, pll_N} !== {1'b0, 1'b1, 8'd40, 5'd2}) begin
         errors++;
         $display("FAIL wake_rst got asl=%b rst=%b M=%0d N=%0d want 0 1 40 2", pll_ASLEEP, pll_RESET, pll_M, pll_N);
      end
      run_to(w + 16);
      checks++;
      if ({pll_RESET, pllbypass} !== 2'b01) begin
         errors++;
         $display("FAIL wake_lock got rst/byp=%b want 01", {pll_RESET, pllbypass});
      end
      run_to(w + 1039);
      checks++;
      if (pllbypass !== 1'b1) begin
         errors++;
         $display("FAIL wake_byp_hold got %b want 1", pllbypass);
      end
      run_to(w + 1040);
      checks++;
      if ({pllbypass, pll_M, pll_N} !== {1'b0, 8'd40, 5'd2}) begin
         errors++;
         $display("FAIL wake_switch got byp=%b M=%0d N=%0d want 0 40 2", pllbypass, pll_M, pll_N);
      end
      run_to(w + 1049);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL wake_end got busy=%b want 0", busy);
      end
   endtask

   task automatic test_sleep_vs_cfg();
      int s, w, t2;
      drive_cfg(1'b1, 8'd50, 5'd3, 2'd2, 1'b1, 6'd7);
      cfg_valid = 1'b1;
      sleep_req = 1'b1;
      tick();
      s = cyc;
      checks++;
      if ({busy, cfg_ready, cfg_err, pll_M, pllbypass} !== {1'b1, 1'b0, 1'b0, 8'd40, 1'b1}) begin
         errors++;
         $display("FAIL both_sleep_wins got busy=%b ready=%b err=%b M=%0d byp=%b want 1 0 0 40 1",
                  busy, cfg_ready, cfg_err, pll_M, pllbypass);
      end
      run_to(s + 29);
      sleep_req = 1'b0;
      w  = s + 30;
      t2 = w + 1050;
      sb.push_back('{at: w + 1048, m: 8'd40, n: 5'd2, od: 2'd1, byp: 1'b0});
      sb.push_back('{at: t2 + 1056, m: 8'd50, n: 5'd3, od: 2'd2, byp: 1'b0});
      run_to(t2 - 1);
      checks++;
      if ({cfg_ready, busy, pll_M} !== {1'b1, 1'b0, 8'd40}) begin
         errors++;
         $display("FAIL both_ready_after_wake got ready=%b busy=%b M=%0d want 1 0 40", cfg_ready, busy, pll_M);
      end
      tick();
      cfg_valid = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL both_accept got busy=%b want 1", busy);
      end
      run_to(t2 + 8);
      checks++;
      if ({pll_M, pll_N, pll_OD, plloutdivby1, plloutdiv} !== {8'd50, 5'd3, 2'd2, 1'b1, 6'd7}) begin
         errors++;
         $display("FAIL both_load got M=%0d N=%0d OD=%0d d1=%b div=%0d want 50 3 2 1 7",
                  pll_M, pll_N, pll_OD, plloutdivby1, plloutdiv);
      end
      run_to(t2 + 1057);
   endtask

   task automatic test_cfg_xtal();
      int t;
      drive_cfg(1'b0, 8'd0, 5'd9, 2'd3, 1'b1, 6'd5);
      cfg_valid = 1'b1;
      tick();
      t = cyc;
      cfg_valid = 1'b0;
      sb.push_back('{at: t + 24, m: 8'd0, n: 5'd9, od: 2'd3, byp: 1'b1});
      checks++;
      if ({cfg_err, busy, pllbypass} !== 3'b011) begin
         errors++;
         $display("FAIL xtal_accept got err/busy/byp=%b want 011", {cfg_err, busy, pllbypass});
      end
      run_to(t + 25);
      checks++;
      if ({pll_RESET, pllbypass, busy, pll_M} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL xtal_end got rst=%b byp=%b busy=%b M=%0d want 1 1 0 0", pll_RESET, pllbypass, busy, pll_M);
      end
   endtask

   task automatic test_reset_lock();
      int t;
      drive_cfg(1'b1, 8'd60, 5'd4, 2'd1, 1'b0, 6'd2);
      cfg_valid = 1'b1;
      tick();
      t = cyc;
      cfg_valid = 1'b0;
      run_to(t + 100);
      checks++;
      if ({pll_RESET, pllbypass, pll_M} !== {1'b0, 1'b1, 8'd60}) begin
         errors++;
         $display("FAIL lock_reached got rst=%b byp=%b M=%0d want 0 1 60", pll_RESET, pllbypass, pll_M);
      end
      rst_n = 1'b0;
      tick();
      sb.delete();
      checks++;
      if ({pllbypass, pll_RESET, pll_ASLEEP, pll_OD, pll_M, pll_N, plloutdivby1, plloutdiv, cfg_ready} !== RESET_VEC
          || busy !== 1'b0) begin
         errors++;
         $display("FAIL lock_rst got %h busy=%b want %h busy=0", {pllbypass, pll_RESET, pll_ASLEEP, pll_OD, pll_M, pll_N,
                  plloutdivby1, plloutdiv, cfg_ready}, busy, RESET_VEC);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset_sleep();
      int s;
      sleep_req = 1'b1;
      tick();
      s = cyc;
      run_to(s + 12);
      checks++;
      if ({pll_ASLEEP, busy} !== 2'b11) begin
         errors++;
         $display("FAIL sleep_reached got asl/busy=%b want 11", {pll_ASLEEP, busy});
      end
      rst_n = 1'b0;
      sleep_req = 1'b0;
      tick();
      checks++;
      if ({pllbypass, pll_RESET, pll_ASLEEP, pll_OD, pll_M, pll_N, plloutdivby1, plloutdiv, cfg_ready} !== RESET_VEC
          || busy !== 1'b0) begin
         errors++;
         $display("FAIL sleep_rst got %h busy=%b want %h busy=0", {pllbypass, pll_RESET, pll_ASLEEP, pll_OD, pll_M, pll_N,
                  plloutdivby1, plloutdiv, cfg_ready}, busy, RESET_VEC);
      end
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      #1;
      test_reset();
      test_cfg_pll();
      test_reject();
      test_sleep();
      test_sleep_vs_cfg();
      test_cfg_xtal();
      test_reset_lock();
      test_reset_sleep();
      repeat (5) tick();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout cyc=%0d want bench to finish", cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "timeout");
   end

endmodule
